mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter. Ports 0 and 1 share one memory port. Grants alternate
// under contention, and read returns are steered back through a latency-matched
// ownership pipeline.
module mem_arbiter #(
  parameter int unsigned DW  = 32,
  parameter int unsigned AW  = 32,
  parameter int unsigned LAT = 1    // memory read latency, 1..4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [7:0]    gnt_cnt0,
  output logic [7:0]    gnt_cnt1
);

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  logic           prio_q;      // port that wins when both request
  logic [LAT-1:0] sr_vld_q;    // read in flight at each stage
  logic [LAT-1:0] sr_port_q;   // owning port of that read
  logic [7:0]     cnt0_q;
  logic [7:0]     cnt1_q;
  logic           rd_issue;

  // Grant decision: sole requester wins, otherwise prio breaks the tie.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (req0 && (!req1 || prio_q == PORT0)) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  // Memory port follows the granted requester; all zero when idle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt0) begin
      mem_en    = 1'b1;
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (gnt1) begin
      mem_en    = 1'b1;
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  assign rd_issue = (gnt0 && !we0) || (gnt1 && !we1);

  // Priority pointer flips to the loser after each grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= PORT0;
    end else if (gnt0) begin
      prio_q <= PORT1;
    end else if (gnt1) begin
      prio_q <= PORT0;
    end
  end

  // Read ownership pipeline; stage LAT-1 lines up with mem_rdata.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_vld_q  <= '0;
      sr_port_q <= '0;
    end else begin
      sr_vld_q[0]  <= rd_issue;
      sr_port_q[0] <= gnt1;
      for (int i = 1; i < LAT; i++) begin
        sr_vld_q[i]  <= sr_vld_q[i-1];
        sr_port_q[i] <= sr_port_q[i-1];
      end
    end
  end

  // Free-running grant counters, wrapping at 8 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0_q <= 8'd0;
      cnt1_q <= 8'd0;
    end else begin
      if (gnt0) cnt0_q <= cnt0_q + 8'd1;
      if (gnt1) cnt1_q <= cnt1_q + 8'd1;
    end
  end

  // Read return steering; data is zeroed when not valid.
  always_comb begin
    rvalid0 = !reset && sr_vld_q[LAT-1] && (sr_port_q[LAT-1] == PORT0);
    rvalid1 = !reset && sr_vld_q[LAT-1] && (sr_port_q[LAT-1] == PORT1);
    rdata0  = rvalid0 ? mem_rdata : '0;
    rdata1  = rvalid1 ? mem_rdata : '0;
  end

  assign gnt_cnt0 = cnt0_q;
  assign gnt_cnt1 = cnt1_q;

endmodule
